// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: a CHUNK-bit ripple slice reused over WIDTH/CHUNK cycles.
// Optional unsigned saturation of sum when SEQ_CHUNK_ADDER_SAT_EN is defined.
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCH = WIDTH / CHUNK;
   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CHUNK-1:0] ChunkMask = '1;

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [IW-1:0]    idx_q;

   int unsigned      shift;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] final_sum;
   logic             msb_cin;
   logic             last;

`ifdef SEQ_CHUNK_ADDER_SAT_EN
   logic sub_q;
`endif

   always_comb begin
      shift     = CHUNK * 32'(idx_q);
      a_chunk   = CHUNK'(op_a_q >> shift);
      b_chunk   = CHUNK'(op_b_q >> shift);
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      res_next  = (res_q & ~(WIDTH'(ChunkMask) << shift))
                | (WIDTH'(chunk_sum[CHUNK-1:0]) << shift);
      // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c_in.
      msb_cin   = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
      last      = (idx_q == IW'(NCH - 1));
      final_sum = res_next;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      if (!sub_q && chunk_sum[CHUNK]) begin
         final_sum = '1;
      end else if (sub_q && !chunk_sum[CHUNK]) begin
         final_sum = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  op_a_q  <= a;
                  op_b_q  <= sub ? ~b : b;
                  carry_q <= sub | cin;
                  idx_q   <= '0;
                  res_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
                  sub_q   <= sub;
`endif
               end
            end
            StRun: begin
               res_q   <= res_next;
               carry_q <= chunk_sum[CHUNK];
               idx_q   <= idx_q + 1'b1;
               if (last) begin
                  sum     <= final_sum;
                  cout    <= chunk_sum[CHUNK];
                  ovf     <= msb_cin ^ chunk_sum[CHUNK];
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  idx_q   <= '0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed table, corner sequences, random vs model.
module tb_seq_chunk_adder;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_bad = 0;

   seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] e_sum;
      logic         e_cout;
      logic         e_ovf;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-word arithmetic, signed overflow from operand/result signs.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                        input logic mcin, output logic [W-1:0] s, output logic co,
                        output logic ov);
      logic [W-1:0] be;
      logic [W:0]   full;
      be   = msub ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, be} + (W+1)'(msub ? 1'b1 : mcin);
      s    = full[W-1:0];
      co   = full[W];
      ov   = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      if (!msub && co) s = '1;
      if (msub && !co) s = '0;
`endif
   endtask

   // Called between edges; returns #1 after the start edge with inputs scrambled.
   task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic ssub,
                           input logic scin);
      a = sa; b = sb; sub = ssub; cin = scin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
   endtask

   // Counts edges until done, checking busy and held sum on the way.
   task automatic wait_done(input logic [W-1:0] held, output int cyc);
      cyc = 0;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         if (done === 1'b1) break;
         check("busy_in_run", busy, 1);
         check("sum_held", sum, held);
         if (cyc > 4 * NCH + 8) begin
            check("done_timeout", done, 1);
            break;
         end
      end
      check("busy_at_done", busy, 0);
   endtask

   task automatic check_res(input string tag, input logic [W-1:0] es, input logic ec,
                            input logic eo);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
   endtask

   initial begin
      int cyc;
      logic [W-1:0] es, prev, ra, rb;
      logic ec, eo, rs, rc;

      tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
`else
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
`endif
      tbl[2] = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_flags", {cout, ovf}, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      prev = '0;
      for (int i = 0; i < 5; i++) begin
         start_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
         check("busy_after_start", busy, 1);
         wait_done(prev, cyc);
         check("latency", cyc, NCH);
         check_res($sformatf("tbl%0d", i), tbl[i].e_sum, tbl[i].e_cout, tbl[i].e_ovf);
         prev = sum;
         @(posedge clk); #1;
         check("done_one_cycle", done, 0);
      end

      // Start during RUN is dropped; only the first operands count.
      model(16'h1234, 16'h1111, 1'b0, 1'b0, es, ec, eo);
      start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(prev, cyc);
      check("ign_latency", cyc, NCH - 2);
      check_res("ign", es, ec, eo);
      prev = sum;
      // Back-to-back: start raised in the done cycle.
      model(16'hF00D, 16'h0FF3, 1'b1, 1'b0, es, ec, eo);
      start_op(16'hF00D, 16'h0FF3, 1'b1, 1'b0);
      wait_done(prev, cyc);
      check("b2b_latency", cyc, NCH);
      check_res("b2b", es, ec, eo);
      prev = sum;
      for (int i = 0; i < NCH + 2; i++) begin
         @(posedge clk); #1;
         check("no_queued_done", {busy, done}, 0);
      end

      // Asynchronous reset at idx=2 aborts the operation.
      start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_sum", sum, 0);
      check("arst_busy_done", {busy, done}, 0);
      check("arst_flags", {cout, ovf}, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("arst_no_done", done, 0);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      model(16'h8001, 16'h8001, 1'b0, 1'b1, es, ec, eo);
      start_op(16'h8001, 16'h8001, 1'b0, 1'b1);
      wait_done(16'h0000, cyc);
      check("post_rst_latency", cyc, NCH);
      check_res("post_rst", es, ec, eo);
      prev = sum;

      // Random operations, back-to-back or with an idle gap.
      for (int i = 0; i < 150; i++) begin
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         if (i % 7 == 0) ra = '1;
         if (i % 11 == 0) rb = '0;
         model(ra, rb, rs, rc, es, ec, eo);
         start_op(ra, rb, rs, rc);
         wait_done(prev, cyc);
         check("rnd_latency", cyc, NCH);
         check_res("rnd", es, ec, eo);
         prev = sum;
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
